// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor decoder back end: response-code values,
// the UART state encoding and the bit-period helper.
package sensor_pkg;

    localparam logic [7:0] RC_STATUS   = 8'h10;
    localparam logic [7:0] RC_TEMP     = 8'h13;
    localparam logic [7:0] RC_HUM      = 8'h14;
    localparam logic [7:0] RC_TEMP_MON = 8'h15;
    localparam logic [7:0] RC_HUM_MON  = 8'h16;
    localparam logic [7:0] RC_TEMP_OFF = 8'h17;
    localparam logic [7:0] RC_HUM_OFF  = 8'h18;
    localparam logic [7:0] RC_BAD_CMD  = 8'hEC;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 transmitter for a single byte. ready is also raised in the last STOP
// cycle so a following byte can start with no idle gap on the line.
module uart_tx_byte
    import sensor_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_t      state_reg, state_next;
    logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       data_reg, data_next;
    logic             tx_reg, tx_next;
    logic             bit_done;

    assign bit_done = (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
    assign ready    = (state_reg == UART_IDLE) || ((state_reg == UART_STOP) && bit_done);
    assign tx       = tx_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= UART_IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            data_reg    <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
            data_reg    <= data_next;
            tx_reg      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_idx_next = bit_idx_reg;
        data_next    = data_reg;
        tx_next      = 1'b1;

        unique case (state_reg)
            UART_IDLE: begin
                clk_cnt_next = '0;
                if (start) begin
                    data_next    = data;
                    bit_idx_next = '0;
                    state_next   = UART_START;
                end
            end
            UART_START: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = UART_DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end
            UART_DATA: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = UART_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    if (start) begin
                        data_next    = data;
                        bit_idx_next = '0;
                        state_next   = UART_START;
                    end else begin
                        state_next = UART_IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = UART_IDLE;
        endcase

        // Line level follows the state being entered, so tx is a clean flop output.
        unique case (state_next)
            UART_START: tx_next = 1'b0;
            UART_DATA:  tx_next = data_next[bit_idx_next];
            default:    tx_next = 1'b1;
        endcase
    end

endmodule

// File: rtl/sensor_response_tx.sv
// Captures decoder {code, value} pairs on the finished rising edge, buffers
// them in a small FIFO and sends each pair to the host as two UART bytes.
module sensor_response_tx
    import sensor_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       finished,
    input  logic [7:0] response_code,
    input  logic [7:0] response,
    output logic       tx,
    output logic       busy,
    output logic       dropped
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;

    logic             finished_d_reg;
    logic             capture_reg;
    logic [15:0]      word_reg;

    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             full, empty, push_ok, pop;
    logic [15:0]      head;

    logic [15:0]      shift_word_reg, shift_word_next;
    logic             byte_sel_reg, byte_sel_next;
    logic             in_flight_reg, in_flight_next;
    logic             dropped_reg;

    logic             uart_start, uart_ready;
    logic [7:0]       uart_data;

    // The edge is registered together with its data so the pushed word is
    // exactly the pair present when finished was first seen high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            finished_d_reg <= 1'b0;
            capture_reg    <= 1'b0;
            word_reg       <= '0;
        end else begin
            finished_d_reg <= finished;
            capture_reg    <= finished & ~finished_d_reg;
            word_reg       <= {response_code, response};
        end
    end

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = capture_reg && (!full || pop);
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= word_reg;
        end
    end

    always_comb begin
        count_next = count_reg;
        unique case ({push_ok, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Two-byte sequencer: on each ready either send the pending value byte or
    // pop the next pair and send its code byte.
    always_comb begin
        pop             = 1'b0;
        uart_start      = 1'b0;
        uart_data       = shift_word_reg[7:0];
        shift_word_next = shift_word_reg;
        byte_sel_next   = byte_sel_reg;

        if (uart_ready) begin
            if (byte_sel_reg) begin
                uart_start    = 1'b1;
                byte_sel_next = 1'b0;
            end else if (!empty) begin
                pop             = 1'b1;
                uart_start      = 1'b1;
                uart_data       = head[15:8];
                shift_word_next = head;
                byte_sel_next   = 1'b1;
            end
        end

        in_flight_next = uart_start ? 1'b1 : (uart_ready ? 1'b0 : in_flight_reg);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            shift_word_reg <= '0;
            byte_sel_reg   <= 1'b0;
            in_flight_reg  <= 1'b0;
            dropped_reg    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg      <= count_next;
            shift_word_reg <= shift_word_next;
            byte_sel_reg   <= byte_sel_next;
            in_flight_reg  <= in_flight_next;
            dropped_reg    <= capture_reg && full && !pop;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clock (clock),
        .reset (reset),
        .start (uart_start),
        .data  (uart_data),
        .tx    (tx),
        .ready (uart_ready)
    );

    assign busy    = !empty || byte_sel_reg || in_flight_reg;
    assign dropped = dropped_reg;

endmodule
